// File: rtl/mult_arbiter.sv
// ============================================================================
//  Module      : mult_arbiter
//  Description : Round-robin request/response arbiter that shares one
//                sequential multiplier between the envelope, SVF and master
//                volume requesters. Latches the winner's operands, drives the
//                multiplier start/ready handshake and returns a Q1.15-scaled,
//                saturated product to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [2:0]            req_i,
    input  logic [3*DATA_W-1:0]   a_i,
    input  logic [3*DATA_W-1:0]   b_i,
    output logic [2:0]            rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_data_o,
    output logic [2:0]            grant_o,
    output logic                  busy_o,
    output logic                  mult_start_o,
    output logic [DATA_W-1:0]     mult_a_o,
    output logic [DATA_W-1:0]     mult_b_o,
    input  logic                  mult_ready_i,
    input  logic [2*DATA_W-1:0]   mult_prod_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Signed DATA_W limits, sign-extended to the product width for comparison
    localparam logic signed [2*DATA_W-1:0] C_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] C_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                     state_q;
    logic [1:0]                 ptr_q;
    logic [1:0]                 owner_q;
    logic [DATA_W-1:0]          mult_a_q;
    logic [DATA_W-1:0]          mult_b_q;
    logic [DATA_W-1:0]          rsp_data_q;
    logic [2:0]                 rsp_valid_q;
    logic [2:0]                 grant_q;
    logic                       busy_q;
    logic                       start_q;

    logic [1:0]                 idx0_d;
    logic [1:0]                 idx1_d;
    logic [1:0]                 idx2_d;
    logic [1:0]                 winner_d;
    logic [DATA_W-1:0]          a_sel_d;
    logic [DATA_W-1:0]          b_sel_d;
    logic signed [2*DATA_W-1:0] shifted_d;
    logic [DATA_W-1:0]          sat_d;

    // Increment modulo 3 (requester indices 0..2)
    function automatic logic [1:0] f_next(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] x);
        logic [2:0] r;
        case (x)
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b001;
        endcase
        return r;
    endfunction

    // Round-robin search starting at ptr: ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        idx0_d = ptr_q;
        idx1_d = f_next(ptr_q);
        idx2_d = f_next(idx1_d);
        if (req_i[idx0_d])
            winner_d = idx0_d;
        else if (req_i[idx1_d])
            winner_d = idx1_d;
        else
            winner_d = idx2_d;
    end

    // Operand mux for the current arbitration winner
    always_comb begin
        a_sel_d = a_i[DATA_W-1:0];
        b_sel_d = b_i[DATA_W-1:0];
        case (winner_d)
            2'd1: begin
                a_sel_d = a_i[2*DATA_W-1:DATA_W];
                b_sel_d = b_i[2*DATA_W-1:DATA_W];
            end
            2'd2: begin
                a_sel_d = a_i[3*DATA_W-1:2*DATA_W];
                b_sel_d = b_i[3*DATA_W-1:2*DATA_W];
            end
            default: ;
        endcase
    end

    // Fixed-point scaling (floor via arithmetic shift) then clamp to DATA_W
    assign shifted_d = $signed(mult_prod_i) >>> FRAC;

    always_comb begin
        if (shifted_d > C_MAX)
            sat_d = C_MAX[DATA_W-1:0];
        else if (shifted_d < C_MIN)
            sat_d = C_MIN[DATA_W-1:0];
        else
            sat_d = shifted_d[DATA_W-1:0];
    end

    // Arbiter FSM with registered Moore outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 3'b000;
            grant_q     <= 3'b000;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_i) begin
                        state_q  <= S_ISSUE;
                        owner_q  <= winner_d;
                        ptr_q    <= f_next(winner_d);
                        mult_a_q <= a_sel_d;
                        mult_b_q <= b_sel_d;
                        grant_q  <= f_onehot(winner_d);
                        busy_q   <= 1'b1;
                        start_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // Any ready pulse here is illegal and deliberately ignored
                    state_q <= S_WAIT;
                    start_q <= 1'b0;
                end
                S_WAIT: begin
                    if (mult_ready_i) begin
                        state_q     <= S_RESP;
                        rsp_data_q  <= sat_d;
                        rsp_valid_q <= f_onehot(owner_q);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 3'b000;
                    grant_q     <= 3'b000;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
    assign mult_start_o = start_q;
    assign mult_a_o     = mult_a_q;
    assign mult_b_o     = mult_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Directed self-checking bench for mult_arbiter; the bench
//                plays the multiplier and the three requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       req;
    logic [W-1:0]     a [3];
    logic [W-1:0]     b [3];
    logic [3*W-1:0]   a_bus;
    logic [3*W-1:0]   b_bus;
    logic [2:0]       rsp_valid;
    logic [W-1:0]     rsp_data;
    logic [2:0]       grant;
    logic             busy;
    logic             mult_start;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic             ready;
    logic [2*W-1:0]   prod;

    int n_pass  = 0;
    int n_total = 0;

    assign a_bus = {a[2], a[1], a[0]};
    assign b_bus = {b[2], b[1], b[0]};

    always #10 clk = ~clk;

    mult_arbiter #(.DATA_W(W), .FRAC(15)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .a_i          (a_bus),
        .b_i          (b_bus),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .grant_o      (grant),
        .busy_o       (busy),
        .mult_start_o (mult_start),
        .mult_a_o     (mult_a),
        .mult_b_o     (mult_b),
        .mult_ready_i (ready),
        .mult_prod_i  (prod)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] onehot(input int i);
        logic [2:0] r;
        r = 3'b001;
        return r << i;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"},  rsp_data,  0);
        chk({tag, "_grant"},     grant,     0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_start"},     mult_start, 0);
        chk({tag, "_mult_a"},    mult_a,    0);
        chk({tag, "_mult_b"},    mult_b,    0);
    endtask

    // Waits for a grant to 'who', plays a multiplier of latency 'lat' (>=2),
    // and checks the response. Ends on the negedge of the following IDLE cycle.
    task automatic serve(input int who, input int lat, input logic [W-1:0] exp_data, input bit drop);
        logic [W-1:0]        sa;
        logic [W-1:0]        sb;
        logic signed [31:0]  p;
        bit                  seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mult_start) seen = 1'b1;
        end
        chk("start_seen", seen, 1);
        if (!seen) return;
        sa = a[who];
        sb = b[who];
        chk("grant", grant, onehot(who));
        chk("busy_issue", busy, 1);
        chk("mult_a", mult_a, sa);
        chk("mult_b", mult_b, sb);
        @(negedge clk);
        chk("start_one_cycle", mult_start, 0);
        a[who] = sa ^ 16'h5A5A;
        repeat (lat - 1) @(negedge clk);
        chk("a_isolated", mult_a, sa);
        chk("wait_no_valid", rsp_valid, 0);
        p = $signed(sa) * $signed(sb);
        prod  = p;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("rsp_valid", rsp_valid, onehot(who));
        chk("rsp_data", rsp_data, exp_data);
        a[who] = sa;
        if (drop) req[who] = 1'b0;
        @(negedge clk);
        chk("idle_valid", rsp_valid, 0);
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
        chk("data_hold", rsp_data, exp_data);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        req   = 3'b000;
        ready = 1'b0;
        prod  = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            b[i] = '0;
        end

        // Reset state, with all three requests already high
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        a[0] = 16'h4000; b[0] = 16'h4000;   // -> 0x2000
        a[1] = 16'h2000; b[1] = 16'hC000;   // -> 0xF000
        a[2] = 16'h7FFF; b[2] = 16'h7FFF;   // -> 0x7FFE
        req  = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous requests: order 0, 1, 2
        serve(0, 3, 16'h2000, 1'b1);
        serve(1, 4, 16'hF000, 1'b1);
        serve(2, 2, 16'h7FFE, 1'b1);

        // Single request, latency 17
        a[0] = 16'h4000; b[0] = 16'h2000;
        req  = 3'b001;
        serve(0, 17, 16'h1000, 1'b1);

        // Spurious ready in IDLE
        prod  = 32'h7FFF_0000;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_start", mult_start, 0);
        chk("spur_valid", rsp_valid, 0);
        chk("spur_data", rsp_data, 16'h1000);

        // Saturation and scaling
        a[1] = 16'h7FFF; b[1] = 16'h7FFF; req = 3'b010;
        serve(1, 3, 16'h7FFE, 1'b1);
        a[1] = 16'h8000; b[1] = 16'h8000; req = 3'b010;
        serve(1, 3, 16'h7FFF, 1'b1);
        a[1] = 16'h8000; b[1] = 16'h7FFF; req = 3'b010;
        serve(1, 3, 16'h8001, 1'b1);
        a[2] = 16'hFFFF; b[2] = 16'h0001; req = 3'b100;
        serve(2, 3, 16'hFFFF, 1'b1);

        // Fairness: requester 2 held, requester 0 re-requests at once
        a[0] = 16'h4000; b[0] = 16'h2000;   // -> 0x1000
        a[2] = 16'h8000; b[2] = 16'h7FFF;   // -> 0x8001
        req  = 3'b101;
        serve(0, 3, 16'h1000, 1'b1);
        req[0] = 1'b1;
        serve(2, 3, 16'h8001, 1'b0);
        serve(0, 3, 16'h1000, 1'b1);
        req[0] = 1'b1;
        serve(2, 3, 16'h8001, 1'b1);
        serve(0, 3, 16'h1000, 1'b1);

        // Reset mid-WAIT (pointer is 2 after granting requester 1)
        a[1] = 16'h1234; b[1] = 16'h4000;   // -> 0x091A
        req  = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mult_start) seen = 1'b1;
        end
        chk("rst_start_seen", seen, 1);
        @(negedge clk);
        chk("rst_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midwait");
        @(negedge clk);
        req   = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);
        prod  = 32'h1234_5678;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_data", rsp_data, 0);

        // Pointer restarted at 0: requesters 1 and 2 -> 1 wins first
        a[2] = 16'hFFFF; b[2] = 16'h0001;
        req  = 3'b110;
        serve(1, 4, 16'h091A, 1'b1);
        serve(2, 2, 16'hFFFF, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Shares the single sequential multiplier between the three multiply requesters in the TT6581 sample path: envelope scaling, SVF, and master volume. The block replaces the fixed `mult_in_mux_o` steering with a request/response handshake and round-robin arbitration. It latches the winning requester's operands, drives the multiplier's start/ready handshake, and returns a fixed-point-scaled, saturated result to the granted requester only. It sits between the requesters and the multiplier, in the same clock domain as the master controller.

## Interface
Parameters:
- `DATA_W`, 16: operand and result width, signed two's complement.
- `FRAC`, 15: arithmetic right shift applied to the product (Q1.15 scaling).

Ports:
- `clk_i`  in  1  system clock, 50 MHz.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `req_i`  in  3  per-requester request (0: env, 1: svf, 2: vol); level, held until response.
- `a_i`  in  3×DATA_W  per-requester operand A; stable while `req_i[n]` is high.
- `b_i`  in  3×DATA_W  per-requester operand B; stable while `req_i[n]` is high.
- `rsp_valid_o`  out  3  one-hot, one-cycle response strobe to the granted requester.
- `rsp_data_o`  out  DATA_W  scaled, saturated product; valid while `rsp_valid_o` is non-zero.
- `grant_o`  out  3  one-hot owner of the multiplier; zero when idle.
- `busy_o`  out  1  high in every state except IDLE.
- `mult_start_o`  out  1  one-cycle start pulse to the multiplier.
- `mult_a_o`  out  DATA_W  latched operand A.
- `mult_b_o`  out  DATA_W  latched operand B.
- `mult_ready_i`  in  1  one-cycle done pulse from the multiplier; `mult_prod_i` is valid in the same cycle.
- `mult_prod_i`  in  2×DATA_W  signed full-width product.

## Operation
- States:
  - IDLE: if any `req_i` is high, go to ISSUE.
  - ISSUE: go to WAIT.
  - WAIT: stay until `mult_ready_i` is high, then go to RESP.
  - RESP: go to IDLE.
- Arbitration happens on the IDLE→ISSUE edge. The arbiter searches `req_i` starting at pointer `ptr` and wrapping modulo 3 (ptr, ptr+1, ptr+2). The first requester found wins.
- On the grant edge:
  - the winner index is latched into `owner`;
  - `a_i[owner]` and `b_i[owner]` are latched into `mult_a_o` and `mult_b_o`;
  - `ptr` is set to (owner+1) mod 3.
- The latched operands and `owner` hold until the next grant. Requester operands may change once the grant is taken.
- In WAIT, on `mult_ready_i`, the result register loads the scaled product:
  - compute `mult_prod_i >>> FRAC` (arithmetic shift, truncation toward −∞);
  - saturate to the signed DATA_W range (max 0x7FFF, min 0x8000 at DATA_W=16).
- Moore outputs, decoded from the state register:
  - `mult_start_o` = (state == ISSUE);
  - `grant_o` = one-hot(`owner`) in ISSUE, WAIT and RESP, zero in IDLE;
  - `rsp_valid_o` = one-hot(`owner`) in RESP only;
  - `busy_o` = (state != IDLE).
- `rsp_data_o` holds its last value outside RESP.
- Requester rule: a requester drops `req_i[n]` on the clock edge at which it samples `rsp_valid_o[n]`. Its request is then already low when the arbiter is back in IDLE.
- `mult_ready_i` is ignored in IDLE, ISSUE and RESP.
- Requests that arrive while `busy_o` is high wait. They are never lost and never preempt the current owner.

## Timing
- Reset (asynchronous, any state, including mid-WAIT):
  - state = IDLE, `ptr` = 0, `owner` = 0;
  - all outputs are 0: `rsp_valid_o`, `rsp_data_o`, `grant_o`, `busy_o`, `mult_start_o`, `mult_a_o`, `mult_b_o`.
  - A multiplication in flight is abandoned. A later `mult_ready_i` is ignored because the arbiter is in IDLE.
- Request sampled high in IDLE at cycle t:
  - ISSUE at t+1, with `mult_start_o` high;
  - WAIT from t+2.
- `mult_ready_i` at cycle w (in WAIT): RESP at w+1, with `rsp_valid_o` and `rsp_data_o` valid. IDLE at w+2.
- Back-to-back: a pending request is sampled in the w+2 IDLE cycle, giving ISSUE at w+3.
- Arbitration overhead is 3 cycles per transaction plus the multiplier latency.
- `mult_ready_i` in the same cycle as ISSUE is not legal from the multiplier; the arbiter ignores it.
- All three requests high at reset release: grants are issued in order 0, 1, 2.

## Test plan
- Single request:
  - stimulus: `req_i` = 3'b001, a = 0x4000, b = 0x2000, multiplier latency 17 cycles;
  - required: `mult_start_o` exactly one cycle; `rsp_valid_o` = 3'b001 one cycle; `rsp_data_o` = 0x1000.
- Simultaneous requests:
  - stimulus: `req_i` = 3'b111 held per the requester rule;
  - required: grant order 0, 1, 2; each requester receives only its own strobe.
- Fairness:
  - stimulus: requester 0 re-requests immediately after every response, requester 2 held high;
  - required: grants alternate 0, 2, 0, 2; requester 2 is never starved.
- Saturation and scaling, at `FRAC` = 15:
  - 0x7FFF × 0x7FFF → 0x7FFE;
  - 0x8000 × 0x8000 → 0x7FFF (saturated);
  - 0x8000 × 0x7FFF → 0x8001;
  - 0xFFFF × 0x0001 → 0xFFFF (truncation toward −∞).
- Reset mid-WAIT:
  - stimulus: assert `rst_ni` low during WAIT, release, then pulse `mult_ready_i`;
  - required: all outputs 0 immediately; no `rsp_valid_o`; next grant honors `ptr` = 0.
- Spurious ready and operand isolation:
  - stimulus: pulse `mult_ready_i` in IDLE; change `a_i[owner]` during WAIT;
  - required: no state change; `mult_a_o` unchanged.
